gray_frame_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter sharing one RGB->grayscale converter among NUM_SRC
//  AXI4-Stream RGB sources. Grants one source per whole frame (SOF on tuser to last line's tlast).

---
 rtl/gray_arb_pkg.sv | 43 ++++
 rtl/gray_frame_arbiter_tag_delay.sv | 35 +++
 rtl/gray_frame_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_gray_frame_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_arb_pkg.sv
// Shared types and round-robin helpers for the gray frame arbiter.
// Supports up to eight sources; IDs are carried as 3-bit values internally.
package gray_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int RGB_WIDTH  = 24;
    localparam int DROP_CNT_W = 16;

    function automatic logic [2:0] rr_next(
        input logic [2:0]  p,
        input int unsigned n
    );
        if (32'(p) + 32'd1 >= n) return 3'd0;
        return p + 3'd1;
    endfunction

    // First requester at or after ptr, wrapping modulo n.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  req,
        input logic [2:0]  ptr,
        input int unsigned n
    );
        logic [2:0] idx;
        logic [2:0] sel;
        logic       hit;
        sel = ptr;
        idx = ptr;
        hit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!hit && 32'(k) < n && req[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
            idx = rr_next(idx, n);
        end
        return sel;
    endfunction

endpackage

// File: rtl/gray_frame_arbiter_tag_delay.sv
// Source-ID tag delay line matching the converter pipeline depth.
// Advances every cycle; tags of invalid slots are forced to zero.
module gray_tag_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] tag_i,
    output logic         valid_o,
    output logic [W-1:0] tag_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     tag_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            tag_q[0] <= valid_i ? tag_i : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/gray_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one RGB->gray converter.
// Define GRAY_ARB_TIMEOUT_EN to enable the GRANT stall watchdog.
module gray_frame_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int RGB_WIDTH    = gray_arb_pkg::RGB_WIDTH,
    parameter int CONV_LATENCY = 3,
    parameter int LINE_CNT_W   = 16,
    parameter int TIMEOUT_CYC  = 4096,
    localparam int ID_W        = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    input  logic [NUM_SRC*RGB_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]           s_axis_tlast,
    input  logic [NUM_SRC-1:0]           s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [RGB_WIDTH-1:0]         m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    input  logic [LINE_CNT_W-1:0]        cfg_frame_lines,
    output logic [ID_W-1:0]              gray_tid,
    output logic                         gray_tid_valid,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic [DROP_CNT_W-1:0]        drop_count,
    output logic                         timeout_err
);

    if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYC < 2 || CONV_LATENCY < 1) begin : g_bad
        $error("gray_frame_arbiter: unsupported parameter set");
    end

    state_e                state_q, state_d;
    logic [ID_W-1:0]       gid_q, gid_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [LINE_CNT_W-1:0] lines_q, lines_d;
    logic [LINE_CNT_W-1:0] cnt_q, cnt_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [3:0]            stray_n;
    logic [NUM_SRC-1:0]    stray, cand;
    logic [ID_W-1:0]       pick;
    logic                  hs;
    logic                  to_fire;

    // Stray acceptance is gated by reset so every output reads 0 in reset.
    assign stray = s_axis_tvalid & ~s_axis_tuser & {NUM_SRC{rst_n}};
    assign cand  = s_axis_tvalid & s_axis_tuser;
    assign pick  = ID_W'(rr_pick(8'(cand), 3'(rr_q), NUM_SRC));

    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        if (state_q == GRANT) begin
            m_axis_tvalid        = s_axis_tvalid[gid_q];
            m_axis_tdata         = s_axis_tdata[gid_q*RGB_WIDTH +: RGB_WIDTH];
            m_axis_tlast         = s_axis_tlast[gid_q];
            m_axis_tuser         = s_axis_tuser[gid_q];
            s_axis_tready[gid_q] = m_axis_tready;
        end else begin
            s_axis_tready = stray;
        end
    end

    assign hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
        stray_n = '0;
        if (state_q == IDLE) begin
            for (int i = 0; i < NUM_SRC; i++) stray_n = stray_n + 4'(stray[i]);
        end
        drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(stray_n);
        drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        lines_d = lines_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = GRANT;
                    gid_d   = pick;
                    cnt_d   = '0;
                    lines_d = (cfg_frame_lines == '0) ? LINE_CNT_W'(1) : cfg_frame_lines;
                end
            end
            GRANT: begin
                if (to_fire) begin
                    state_d = IDLE;
                    rr_d    = ID_W'(rr_next(3'(gid_q), NUM_SRC));
                end else if (hs && m_axis_tlast) begin
                    if (cnt_q == lines_q - LINE_CNT_W'(1)) begin
                        state_d = IDLE;
                        rr_d    = ID_W'(rr_next(3'(gid_q), NUM_SRC));
                    end else begin
                        cnt_d = cnt_q + LINE_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gid_q   <= '0;
            rr_q    <= '0;
            lines_q <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            lines_q <= lines_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

`ifdef GRAY_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] stall_q, stall_d;
    logic          to_q;

    always_comb begin
        stall_d = '0;
        to_fire = 1'b0;
        if (state_q == GRANT && !hs) begin
            if (stall_q == TW'(TIMEOUT_CYC - 1)) to_fire = 1'b1;
            else stall_d = stall_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            stall_q <= stall_d;
            to_q    <= to_fire;
        end
    end

    assign timeout_err = to_q;
`else
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    gray_tag_delay #(
        .DEPTH (CONV_LATENCY),
        .W     (ID_W)
    ) u_tag (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (hs),
        .tag_i   (gid_q),
        .valid_o (gray_tid_valid),
        .tag_o   (gray_tid)
    );

    assign grant_id   = gid_q;
    assign busy       = (state_q == GRANT);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_gray_frame_arbiter.sv
// Self-checking bench for gray_frame_arbiter (default build).
// Per-source beat queues drive stimulus; a scoreboard checks the forwarded stream.
module tb_gray_frame_arbiter;

    localparam int N   = 4;
    localparam int W   = 24;
    localparam int LAT = 3;
    localparam int LW  = 16;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
    logic [N*W-1:0] s_tdata;
    logic           m_tvalid, m_tready, m_tlast, m_tuser;
    logic [W-1:0]   m_tdata;
    logic [LW-1:0]  cfg_lines;
    logic [IDW-1:0] gray_tid, grant_id;
    logic           gray_tid_valid, busy, timeout_err;
    logic [15:0]    drop_count;

    gray_frame_arbiter #(
        .NUM_SRC      (N),
        .RGB_WIDTH    (W),
        .CONV_LATENCY (LAT),
        .LINE_CNT_W   (LW),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tdata    (s_tdata),
        .s_axis_tlast    (s_tlast),
        .s_axis_tuser    (s_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tlast    (m_tlast),
        .m_axis_tuser    (m_tuser),
        .cfg_frame_lines (cfg_lines),
        .gray_tid        (gray_tid),
        .gray_tid_valid  (gray_tid_valid),
        .grant_id        (grant_id),
        .busy            (busy),
        .drop_count      (drop_count),
        .timeout_err     (timeout_err)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic         u;
    } beat_t;

    typedef struct {
        logic [W-1:0]   d;
        logic           l;
        logic           u;
        logic [IDW-1:0] src;
    } exp_t;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] u;
        logic [N-1:0] r;
        int           inc;
    } vec_t;

    beat_t          srcq [N][$];
    exp_t           sb[$];
    logic [IDW:0]   tagp [LAT];
    vec_t           vt [6];
    int             checks = 0;
    int             failures = 0;
    int             exp_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        s_tdata  = '0;
    endtask

    task automatic add_beat(input int s, input logic [W-1:0] d,
                            input logic u, input logic l, input bit fwd);
        beat_t b;
        exp_t  e;
        b.d = d; b.u = u; b.l = l;
        srcq[s].push_back(b);
        if (fwd) begin
            e.d = d; e.u = u; e.l = l; e.src = IDW'(s);
            sb.push_back(e);
        end
    endtask

    // Negedge monitor: tag line model and forwarded-beat scoreboard.
    task automatic sample();
        exp_t e;
        chk("tag_valid", 32'(gray_tid_valid), 32'(tagp[LAT-1][IDW]));
        chk("tag_id", 32'(gray_tid), 32'(tagp[LAT-1][IDW-1:0]));
        for (int k = LAT - 1; k > 0; k--) tagp[k] = tagp[k-1];
        tagp[0] = '0;
        if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
            end else begin
                e = sb.pop_front();
                chk("m_data", 32'(m_tdata), 32'(e.d));
                chk("m_last", 32'(m_tlast), 32'(e.l));
                chk("m_user", 32'(m_tuser), 32'(e.u));
                chk("grant_id", 32'(grant_id), 32'(e.src));
                tagp[0] = {1'b1, e.src};
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int stall_after, input int stall_len, input int maxc);
        int cyc  = 0;
        int acc  = 0;
        int left = stall_len;
        while (pending() && cyc < maxc) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() > 0) begin
                    s_tvalid[i]       = 1'b1;
                    s_tdata[i*W +: W] = srcq[i][0].d;
                    s_tlast[i]        = srcq[i][0].l;
                    s_tuser[i]        = srcq[i][0].u;
                end else begin
                    s_tvalid[i]       = 1'b0;
                    s_tdata[i*W +: W] = '0;
                    s_tlast[i]        = 1'b0;
                    s_tuser[i]        = 1'b0;
                end
            end
            m_tready = !(acc == stall_after && left > 0);
            @(negedge clk);
            if (!m_tready) begin
                chk("stall_tready", 32'(s_tready), 0);
                chk("stall_mvalid", 32'(m_tvalid), 1);
                if (sb.size() > 0) chk("stall_data", 32'(m_tdata), 32'(sb[0].d));
                left--;
            end
            sample();
            if (m_tvalid && m_tready) acc++;
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) void'(srcq[i].pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (pending()) begin
            checks++;
            failures++;
            $display("FAIL run_budget actual=pending required=drained");
            for (int i = 0; i < N; i++) srcq[i].delete();
        end
        clear_inputs();
        m_tready = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_tready  = 1'b1;
        cfg_lines = LW'(1);
        sb.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
        for (int k = 0; k < LAT; k++) tagp[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mvalid", 32'(m_tvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_tagv", 32'(gray_tid_valid), 0);
        chk("rst_tready", 32'(s_tready), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{v: 4'b0000, u: 4'b0000, r: 4'b0000, inc: 0};
        vt[1] = '{v: 4'b0010, u: 4'b0000, r: 4'b0010, inc: 1};
        vt[2] = '{v: 4'b1011, u: 4'b0000, r: 4'b1011, inc: 3};
        vt[3] = '{v: 4'b0101, u: 4'b1010, r: 4'b0101, inc: 2};
        vt[4] = '{v: 4'b1111, u: 4'b0000, r: 4'b1111, inc: 4};
        vt[5] = '{v: 4'b0000, u: 4'b1111, r: 4'b0000, inc: 0};

        apply_reset();

        // Stray mid-frame beats while idle are dropped and counted.
        for (int k = 0; k < 5; k++) add_beat(1, W'(24'h100 + k), 1'b0, 1'b0, 1'b0);
        run(-1, 0, 20);
        chk("stray_drop", 32'(drop_count), 5);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_sb", 32'(sb.size()), 0);

        exp_drop = 5;
        for (int j = 0; j < 6; j++) begin
            s_tvalid = vt[j].v;
            s_tuser  = vt[j].u;
            @(negedge clk);
            chk("vec_tready", 32'(s_tready), 32'(vt[j].r));
            chk("vec_mvalid", 32'(m_tvalid), 0);
            sample();
            @(posedge clk);
            #1;
            exp_drop += vt[j].inc;
            chk("vec_drop", 32'(drop_count), 32'(exp_drop));
        end
        clear_inputs();
        idle(1);
        chk("vec_busy", 32'(busy), 0);

        // 2x2 frame from source 0.
        cfg_lines = LW'(2);
        add_beat(0, 24'h112233, 1'b1, 1'b0, 1'b1);
        add_beat(0, 24'h445566, 1'b0, 1'b1, 1'b1);
        add_beat(0, 24'h778899, 1'b0, 1'b0, 1'b1);
        add_beat(0, 24'hAABBCC, 1'b0, 1'b1, 1'b1);
        run(-1, 0, 40);
        chk("f1_busy_end", 32'(busy), 0);
        idle(LAT + 1);
        chk("f1_sb", 32'(sb.size()), 0);

        // Stall mid-line; cfg 0 behaves as a single line.
        cfg_lines = '0;
        add_beat(2, 24'h200001, 1'b1, 1'b0, 1'b1);
        add_beat(2, 24'h200002, 1'b0, 1'b0, 1'b1);
        add_beat(2, 24'h200003, 1'b1, 1'b0, 1'b1);
        add_beat(2, 24'h200004, 1'b0, 1'b1, 1'b1);
        run(2, 10, 60);
        chk("stall_busy_end", 32'(busy), 0);
        chk("stall_grant", 32'(grant_id), 2);
        idle(LAT + 1);
        chk("stall_sb", 32'(sb.size()), 0);

        // All sources raise SOF together, two single-beat frames each.
        apply_reset();
        cfg_lines = LW'(1);
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                add_beat(s, W'(24'h300000 + r * 16 + s), 1'b1, 1'b1, 1'b1);
            end
        end
        sb.delete();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                exp_t e;
                e.d = W'(24'h300000 + r * 16 + s);
                e.l = 1'b1; e.u = 1'b1; e.src = IDW'(s);
                sb.push_back(e);
            end
        end
        run(-1, 0, 80);
        idle(LAT + 1);
        chk("rr_sb", 32'(sb.size()), 0);
        chk("rr_busy", 32'(busy), 0);

        // Reset in the middle of line 1 of a 3-line frame.
        cfg_lines = LW'(3);
        add_beat(3, 24'h400001, 1'b1, 1'b0, 1'b1);
        add_beat(3, 24'h400002, 1'b0, 1'b1, 1'b1);
        add_beat(3, 24'h400003, 1'b0, 1'b0, 1'b1);
        run(-1, 0, 20);
        s_tvalid[3] = 1'b1;
        s_tdata[3*W +: W] = 24'h400004;
        s_tlast[3] = 1'b1;
        m_tready = 1'b0;
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_mvalid", 32'(m_tvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mvalid", 32'(m_tvalid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant", 32'(grant_id), 0);
        chk("mid_rst_tready", 32'(s_tready), 0);
        chk("mid_rst_drop", 32'(drop_count), 0);
        chk("mid_rst_tagv", 32'(gray_tid_valid), 0);
        clear_inputs();
        sb.delete();
        for (int k = 0; k < LAT; k++) tagp[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_tready = 1'b1;
        cfg_lines = LW'(1);
        add_beat(1, 24'h500001, 1'b1, 1'b1, 1'b1);
        run(-1, 0, 20);
        chk("post_rst_grant", 32'(grant_id), 1);
        chk("post_rst_busy", 32'(busy), 0);
        idle(LAT + 1);
        chk("post_rst_sb", 32'(sb.size()), 0);
        chk("timeout_quiet", 32'(timeout_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
